relu_stream_activation: RTL

- Streaming, multi-mode successor to the flat full-tensor ReLU stage.
- Accepts a feature map as LANES elements per beat over a valid/ready handshake instead of one very wide bus.
- Applies a per-frame activation mode: bypass, ReLU, leaky ReLU or clipped ReLU.
- Output is registered and frame-delimited; it sits between a convolution/pooling producer and the next layer's input buffer.

---
 rtl/cnn_act_pkg.sv | 18 +
 rtl/act_lane.sv | 42 ++++
 rtl/relu_stream_activation.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cnn_act_pkg.sv
// Purpose: shared activation-mode encodings and lane slicing helper for the CNN activation stages.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cnn_act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_e;

  // Bit offset of lane 'lane' in a flat vector of 'width'-bit elements, lane 0 lowest.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Purpose: single-element activation (bypass / ReLU / leaky / clipped) on a signed element.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller owns the handshake.
module act_lane
  import cnn_act_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [BITWIDTH-1:0] i_x,
  input  act_mode_e           i_mode,
  input  logic [BITWIDTH-2:0] i_clip,
  output logic [BITWIDTH-1:0] o_y
);

  logic                w_neg;
  logic [BITWIDTH-1:0] w_leak;
  logic [BITWIDTH-1:0] w_clip_ext;

  // Sign bit decides every non-bypass mode; the clip bound is non-negative by construction,
  // so an unsigned compare against a non-negative x is exact.
  assign w_neg      = i_x[BITWIDTH-1];
  assign w_leak     = BITWIDTH'($signed(i_x) >>> LEAK_SHIFT);
  assign w_clip_ext = {1'b0, i_clip};

  // Select the activated value for the current mode.
  always_comb begin
    o_y = i_x;
    case (i_mode)
      ACT_BYPASS: o_y = i_x;
      ACT_RELU:   o_y = w_neg ? '0 : i_x;
      ACT_LEAKY:  o_y = w_neg ? w_leak : i_x;
      ACT_CLIP: begin
        if (w_neg)                o_y = '0;
        else if (i_x > w_clip_ext) o_y = w_clip_ext;
        else                      o_y = i_x;
      end
      default:    o_y = i_x;
    endcase
  end

endmodule

// File: rtl/relu_stream_activation.sv
// Purpose: streaming per-frame activation over LANES elements per beat, frame-delimited output.
// Latency: 1 cycle from input acceptance to out_valid; one beat per cycle sustained.
// Backpressure: single output register; in_ready = !out_valid || out_ready, output held while stalled.
module relu_stream_activation
  import cnn_act_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int LANES       = 4,
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3,
  parameter int LEAK_SHIFT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [BITWIDTH-2:0]       clip_max,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BITWIDTH*LANES-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BITWIDTH*LANES-1:0] out_data,
  output logic                      out_last,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int ELEMS = DATAWIDTH * DATAHEIGHT * DATACHANNEL;
  localparam int BEATS = ELEMS / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // A frame must split into whole beats.
  if ((ELEMS % LANES) != 0) begin : g_bad_beats
    $error("relu_stream_activation: feature-map element count is not a multiple of LANES");
  end

  logic [CNT_W-1:0]          r_cnt;
  act_mode_e                 r_mode;
  logic [BITWIDTH-2:0]       r_clip;
  logic                      r_out_valid;
  logic [BITWIDTH*LANES-1:0] r_out_data;
  logic                      r_out_last;
  logic                      r_frame_done;
  logic                      r_busy;

  logic                      w_in_fire;
  logic                      w_out_fire;
  logic                      w_first;
  logic                      w_last_in;
  act_mode_e                 w_mode;
  logic [BITWIDTH-2:0]       w_clip;
  logic [BITWIDTH*LANES-1:0] w_act;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_first    = (r_cnt == '0);
  assign w_last_in  = (r_cnt == CNT_W'(BEATS - 1));

  // Beat 0 uses the live mode/clip so the frame's settings apply from its very first beat.
  assign w_mode = w_first ? act_mode_e'(mode) : r_mode;
  assign w_clip = w_first ? clip_max : r_clip;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    act_lane #(
      .BITWIDTH  (BITWIDTH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_act_lane (
      .i_x   (in_data[lane_lsb(k, BITWIDTH) +: BITWIDTH]),
      .i_mode(w_mode),
      .i_clip(w_clip),
      .o_y   (w_act[lane_lsb(k, BITWIDTH) +: BITWIDTH])
    );
  end

  // Beat counter and per-frame capture of mode and clip bound on beat 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mode <= ACT_BYPASS;
      r_clip <= '0;
    end else if (w_in_fire) begin
      r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
      if (w_first) begin
        r_mode <= act_mode_e'(mode);
        r_clip <= clip_max;
      end
    end
  end

  // Output register: load on acceptance, drain on downstream ready, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_act;
      r_out_last  <= w_last_in;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Frame status: pulse when the last beat leaves; a new frame starting that cycle keeps busy up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= w_out_fire && r_out_last;
      if (w_in_fire && w_first)          r_busy <= 1'b1;
      else if (w_out_fire && r_out_last) r_busy <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule
